// File: rtl/hack_rom_loader.sv
// -----------------------------------------------------------------------------
// hack_rom_loader
//
// Instruction memory for the Hack CPU together with a byte-stream program
// loader. The CPU fetch path reads rom[pc] combinationally. A framed program
// image arrives one byte at a time and is written into the ROM. The CPU is
// held in reset until a complete image with a matching checksum is committed.
//
// Frame layout (byte order):
//   SYNC_BYTE, LEN_HI, LEN_LO, {HI, LO} x N, CHK
//   CHK = XOR of LEN_HI, LEN_LO and every data byte (SYNC_BYTE excluded).
//
// Handshake: a byte transfers on a rising clk edge where rx_valid and
// rx_ready are both 1. The sender holds rx_data stable while rx_valid is high
// and rx_ready is low. rx_ready is low only during the single COMMIT cycle.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   pc           in   [15:0] CPU program counter
//   instruction  out  [15:0] rom[pc] when pc is inside the ROM, else 0
//   rx_data      in   [7:0]  incoming byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  loader accepts a byte this cycle
//   cpu_reset    out  registered CPU reset, low only in RUN
//   load_done    out  registered, last image committed successfully
//   load_error   out  registered, last image failed (length or checksum)
//   words_loaded out  [ADDR_WIDTH:0] words written in current/most recent load
//   state_dbg    out  [3:0] current loader state, for observation only
// -----------------------------------------------------------------------------
module hack_rom_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           pc,
    output logic [15:0]           instruction,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic [3:0]            state_dbg
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Largest legal word count; words_loaded saturates here.
    localparam logic [ADDR_WIDTH:0] WL_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LEN_HI  = 4'd1;
    localparam logic [3:0] ST_LEN_LO  = 4'd2;
    localparam logic [3:0] ST_DATA_HI = 4'd3;
    localparam logic [3:0] ST_DATA_LO = 4'd4;
    localparam logic [3:0] ST_CHECK   = 4'd5;
    localparam logic [3:0] ST_COMMIT  = 4'd6;
    localparam logic [3:0] ST_RUN     = 4'd7;
    localparam logic [3:0] ST_ERROR   = 4'd8;

    logic [15:0]           rom [0:DEPTH-1];

    logic [3:0]            state;
    logic [7:0]            chk_q;      // running XOR checksum
    logic [7:0]            len_hi_q;   // latched LEN_HI byte
    logic [15:0]           len_q;      // word count N of the current frame
    logic [7:0]            hi_q;       // latched high byte of current word
    logic [ADDR_WIDTH-1:0] waddr;      // next ROM write address

    logic                  accept;
    logic [15:0]           len_n;
    logic                  len_too_big;
    logic                  last_word;
    logic                  pc_in_range;
    logic                  rom_we;

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // Fetch path: asynchronous read. Addresses outside the ROM return 0
    // rather than aliasing onto low addresses.
    // ------------------------------------------------------------------
    assign pc_in_range = ({1'b0, pc} < 17'(DEPTH));
    assign instruction = pc_in_range ? rom[pc[ADDR_WIDTH-1:0]] : 16'h0000;

    // ------------------------------------------------------------------
    // Handshake and frame decode helpers
    // ------------------------------------------------------------------
    assign rx_ready    = (state != ST_COMMIT);
    assign accept      = rx_valid & rx_ready;

    // Length as it will be once the LEN_LO byte is taken.
    assign len_n       = {len_hi_q, rx_data};
    assign len_too_big = ({1'b0, len_n} > 17'(DEPTH));

    // The word being written now is the final one of the frame.
    assign last_word   = ((17'(words_loaded) + 17'd1) == {1'b0, len_q});

    assign rom_we      = accept && (state == ST_DATA_LO);

    // ------------------------------------------------------------------
    // ROM write port. Not reset: a reset mid-load leaves already written
    // words in place. Read-during-write returns the old word because the
    // array only updates on the clock edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom[waddr] <= {hi_q, rx_data};
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cpu_reset    <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
            chk_q        <= 8'h00;
            len_hi_q     <= 8'h00;
            len_q        <= 16'h0000;
            hi_q         <= 8'h00;
            waddr        <= '0;
        end else begin
            case (state)
                // Waiting for a frame. Any non-sync byte is consumed and
                // dropped so a stray byte never stalls the receiver.
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (accept && (rx_data == SYNC_BYTE)) begin
                        state        <= ST_LEN_HI;
                        cpu_reset    <= 1'b1;
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                        words_loaded <= '0;
                        chk_q        <= 8'h00;
                        waddr        <= '0;
                    end
                end

                ST_LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= rx_data;
                        chk_q    <= chk_q ^ rx_data;
                        state    <= ST_LEN_LO;
                    end
                end

                ST_LEN_LO: begin
                    if (accept) begin
                        len_q <= len_n;
                        chk_q <= chk_q ^ rx_data;
                        if (len_too_big) begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                        end else if (len_n == 16'h0000) begin
                            state <= ST_CHECK;
                        end else begin
                            state <= ST_DATA_HI;
                        end
                    end
                end

                ST_DATA_HI: begin
                    if (accept) begin
                        hi_q  <= rx_data;
                        chk_q <= chk_q ^ rx_data;
                        state <= ST_DATA_LO;
                    end
                end

                ST_DATA_LO: begin
                    if (accept) begin
                        waddr <= waddr + 1'b1;
                        chk_q <= chk_q ^ rx_data;
                        if (words_loaded != WL_MAX) begin
                            words_loaded <= words_loaded + 1'b1;
                        end
                        state <= last_word ? ST_CHECK : ST_DATA_HI;
                    end
                end

                // Sync bytes in here are just checksum values; no resync.
                ST_CHECK: begin
                    if (accept) begin
                        if (rx_data == chk_q) begin
                            state <= ST_COMMIT;
                        end else begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end

                // Single cycle with rx_ready low; releases the CPU.
                ST_COMMIT: begin
                    load_done <= 1'b1;
                    cpu_reset <= 1'b0;
                    state     <= ST_RUN;
                end

                default: begin
                    state     <= ST_IDLE;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// -----------------------------------------------------------------------------
// tb_hack_rom_loader
//
// Directed bench for hack_rom_loader: a table of ROM read vectors plus
// hand-written frame sequences for load, checksum error, length error,
// zero-length, sync-in-data, restart from RUN and reset mid-load.
// -----------------------------------------------------------------------------
module tb_hack_rom_loader;

    localparam int AW = 12;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_HI  = 4'd1;
    localparam logic [3:0] S_DATA_LO = 4'd4;
    localparam logic [3:0] S_COMMIT  = 4'd6;
    localparam logic [3:0] S_RUN     = 4'd7;
    localparam logic [3:0] S_ERROR   = 4'd8;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   pc;
    logic [15:0]   instruction;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;
    logic [3:0]    state_dbg;

    always #5 clk = ~clk;

    hack_rom_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .instruction  (instruction),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    logic [7:0] tx_q[$];

    // Present one byte from a negedge; it transfers on the first posedge
    // where rx_ready is seen high. Returns just after that accept edge.
    task automatic send_byte(input logic [7:0] b);
        bit sent = 0;
        for (int t = 0; t < 8 && !sent; t++) begin
            @(negedge clk);
            rx_data  = b;
            rx_valid = 1'b1;
            if (rx_ready) begin
                @(posedge clk);
                sent = 1;
            end
        end
        if (!sent) begin
            total++;
            bad++;
            $display("FAIL rx_ready_timeout: got %h expected %h", rx_ready, 1'b1);
        end
    endtask

    task automatic send_q();
        while (tx_q.size() > 0) begin
            send_byte(tx_q.pop_front());
        end
    endtask

    // Move to the next negedge with the byte stream idle.
    task automatic settle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] a,
                              input logic [15:0] exp);
        pc = a;
        #1;
        check(name, 32'(instruction), 32'(exp));
    endtask

    // ---------------- read vector table ----------------
    typedef struct {
        logic [15:0] pc;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got %0d expected %0d", 1, 0);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // After the first good frame: rom[0]=0005, rom[1]=EC10; anything
        // at or above 4096 reads 0 (4097 must not alias onto rom[1]).
        rd_tab[0] = '{pc: 16'd0,      exp: 16'h0005};
        rd_tab[1] = '{pc: 16'd1,      exp: 16'hEC10};
        rd_tab[2] = '{pc: 16'd4096,   exp: 16'h0000};
        rd_tab[3] = '{pc: 16'd4097,   exp: 16'h0000};
        rd_tab[4] = '{pc: 16'hFFFF,   exp: 16'h0000};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pc       = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // ---- reset state, 10 idle cycles ----
        repeat (10) @(negedge clk);
        check("rst_cpu_reset",  32'(cpu_reset),    32'd1);
        check("rst_load_done",  32'(load_done),    32'd0);
        check("rst_load_error", 32'(load_error),   32'd0);
        check("rst_rx_ready",   32'(rx_ready),     32'd1);
        check("rst_words",      32'(words_loaded), 32'd0);
        check("rst_state",      32'(state_dbg),    32'(S_IDLE));

        // ---- good two-word frame ----
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'hFB};
        send_q();
        settle();   // one edge after the checksum accept
        check("commit_state",     32'(state_dbg), 32'(S_COMMIT));
        check("commit_rx_ready",  32'(rx_ready),  32'd0);
        check("commit_cpu_reset", 32'(cpu_reset), 32'd1);
        settle();   // COMMIT -> RUN edge
        check("run_state",     32'(state_dbg),    32'(S_RUN));
        check("run_cpu_reset", 32'(cpu_reset),    32'd0);
        check("run_load_done", 32'(load_done),    32'd1);
        check("run_load_err",  32'(load_error),   32'd0);
        check("run_words",     32'(words_loaded), 32'd2);
        for (int i = 0; i < 5; i++) begin
            read_check($sformatf("rd_tab%0d", i), rd_tab[i].pc, rd_tab[i].exp);
        end

        // ---- bad checksum, then correct resend ----
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'hFA};
        send_q();
        settle();
        check("chk_err_state",     32'(state_dbg),  32'(S_ERROR));
        check("chk_err_load_err",  32'(load_error), 32'd1);
        check("chk_err_load_done", 32'(load_done),  32'd0);
        settle();
        check("chk_err_cpu_reset", 32'(cpu_reset),  32'd1);
        tx_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h05, 8'hEC, 8'h10, 8'hFB};
        send_q();
        settle();
        settle();
        check("resend_load_done", 32'(load_done),  32'd1);
        check("resend_load_err",  32'(load_error), 32'd0);
        check("resend_cpu_reset", 32'(cpu_reset),  32'd0);

        // ---- oversize length: N = 4097 ----
        tx_q = '{8'hA5, 8'h10, 8'h01};
        send_q();
        settle();
        check("len_err_state",    32'(state_dbg),    32'(S_ERROR));
        check("len_err_load_err", 32'(load_error),   32'd1);
        check("len_err_cpu_rst",  32'(cpu_reset),    32'd1);
        // trailing bytes must be dropped, not written
        tx_q = '{8'h12, 8'h34, 8'h56};
        send_q();
        settle();
        check("len_err_stay",  32'(state_dbg),    32'(S_ERROR));
        check("len_err_words", 32'(words_loaded), 32'd0);
        read_check("len_err_rom0", 16'd0, 16'h0005);
        read_check("len_err_rom1", 16'd1, 16'hEC10);

        // ---- zero-length frame ----
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        settle();
        settle();
        check("zero_state",     32'(state_dbg),    32'(S_RUN));
        check("zero_words",     32'(words_loaded), 32'd0);
        check("zero_load_done", 32'(load_done),    32'd1);
        check("zero_cpu_reset", 32'(cpu_reset),    32'd0);

        // ---- stray byte in RUN, then restart with sync ----
        send_byte(8'h3C);
        settle();
        check("stray_state",     32'(state_dbg), 32'(S_RUN));
        check("stray_cpu_reset", 32'(cpu_reset), 32'd0);
        send_byte(8'hA5);
        settle();
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        check("restart_load_done", 32'(load_done), 32'd0);
        check("restart_state",     32'(state_dbg), 32'(S_LEN_HI));

        // ---- data bytes equal to sync: A5 00 01 A5 A5 01 ----
        tx_q = '{8'h00, 8'h01, 8'hA5, 8'hA5, 8'h01};
        send_q();
        settle();
        settle();
        check("syncdata_done",  32'(load_done),    32'd1);
        check("syncdata_words", 32'(words_loaded), 32'd1);
        read_check("syncdata_rom0", 16'd0, 16'hA5A5);
        read_check("syncdata_rom1", 16'd1, 16'hEC10);

        // ---- reset in the middle of the data phase ----
        tx_q = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
        send_q();
        settle();
        check("mid_state", 32'(state_dbg),    32'(S_DATA_LO));
        check("mid_words", 32'(words_loaded), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_state",     32'(state_dbg),    32'(S_IDLE));
        check("mid_rst_cpu_reset", 32'(cpu_reset),    32'd1);
        check("mid_rst_words",     32'(words_loaded), 32'd0);
        check("mid_rst_rx_ready",  32'(rx_ready),     32'd1);
        read_check("mid_rst_rom0", 16'd0, 16'h1234);
        read_check("mid_rst_rom1", 16'd1, 16'h5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
